attitude_classifier: RTL and testbench

ATTITUDE_CLASSIFIER -- requirements
Module: attitude_classifier

---
 rtl/attitude_pkg.sv | 13 +
 rtl/axis_hysteresis.sv | 55 +++++
 rtl/attitude_classifier.sv | 137 +++++++++++++
 tb/tb_attitude_classifier.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/attitude_pkg.sv
// Shared constants for the attitude classifier.
// Code bit positions and the default hysteresis thresholds.
package attitude_pkg;

  localparam int ROLL_SGN   = 3;
  localparam int PITCH_SGN  = 2;
  localparam int ROLL_OVER  = 1;
  localparam int PITCH_OVER = 0;

  localparam logic [15:0] THRESH_ON_DEF  = 16'd1820;
  localparam logic [15:0] THRESH_OFF_DEF = 16'd1456;

endpackage

// File: rtl/axis_hysteresis.sv
// One axis: registered sign and saturated magnitude,
// plus the hysteresis candidate for its over bit.
import attitude_pkg::*;

module axis_hysteresis #(
  parameter logic [15:0] THRESH_ON  = THRESH_ON_DEF,
  parameter logic [15:0] THRESH_OFF = THRESH_OFF_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [15:0] sample_i,
  input  logic        over_i,
  output logic        sgn_o,
  output logic        over_o
);

  logic [15:0] mag_q, mag_d;
  logic        sgn_q, sgn_d;

  always_comb begin
    mag_d = mag_q;
    sgn_d = sgn_q;
    if (valid_i) begin
      sgn_d = sample_i[15];
      if (!sample_i[15])
        mag_d = sample_i;
      else if (sample_i == 16'h8000)
        mag_d = 16'h7FFF;
      else
        mag_d = ~sample_i + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mag_q <= '0;
      sgn_q <= 1'b0;
    end else begin
      mag_q <= mag_d;
      sgn_q <= sgn_d;
    end
  end

  always_comb begin
    over_o = over_i;
    if (!over_i && mag_q > THRESH_ON)
      over_o = 1'b1;
    else if (over_i && mag_q < THRESH_OFF)
      over_o = 1'b0;
  end

  assign sgn_o = sgn_q;

endmodule

// File: rtl/attitude_classifier.sv
// Roll/pitch attitude classifier: per-axis hysteresis,
// debounce over accepted samples, and a staleness timeout.
import attitude_pkg::*;

module attitude_classifier #(
  parameter logic [15:0] THRESH_ON      = THRESH_ON_DEF,
  parameter logic [15:0] THRESH_OFF     = THRESH_OFF_DEF,
  parameter int          HOLD_COUNT     = 4,
  parameter int          TIMEOUT_CYCLES = 2_500_000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Valid,
  input  logic [15:0] i_Roll,
  input  logic [15:0] i_Pitch,
  output logic [3:0]  o_Attitude,
  output logic        o_Changed,
  output logic        o_Stale
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    HOLD     = 4'(HOLD_COUNT);

  logic          s1_vld_q, s2_vld_q;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    att_q, att_d;
  logic [3:0]    pend_q, pend_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          chg_q, chg_d;
  logic          stale_q, stale_d;
  logic          r_sgn, r_over, p_sgn, p_over;

  // Over bits see the commit made on this same edge,
  // so back-to-back samples behave strictly in order.
  axis_hysteresis #(
    .THRESH_ON (THRESH_ON),
    .THRESH_OFF(THRESH_OFF)
  ) u_roll (
    .clk_i   (i_Clk),
    .rst_i   (i_Rst),
    .valid_i (i_Valid),
    .sample_i(i_Roll),
    .over_i  (att_d[ROLL_OVER]),
    .sgn_o   (r_sgn),
    .over_o  (r_over)
  );

  axis_hysteresis #(
    .THRESH_ON (THRESH_ON),
    .THRESH_OFF(THRESH_OFF)
  ) u_pitch (
    .clk_i   (i_Clk),
    .rst_i   (i_Rst),
    .valid_i (i_Valid),
    .sample_i(i_Pitch),
    .over_i  (att_d[PITCH_OVER]),
    .sgn_o   (p_sgn),
    .over_o  (p_over)
  );

  always_comb begin
    cand_d             = '0;
    cand_d[ROLL_SGN]   = r_sgn;
    cand_d[PITCH_SGN]  = p_sgn;
    cand_d[ROLL_OVER]  = r_over;
    cand_d[PITCH_OVER] = p_over;
  end

  always_comb begin
    att_d   = att_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    chg_d   = 1'b0;
    stale_d = stale_q;
    tmo_d   = tmo_q;
    if (s2_vld_q) begin
      stale_d = 1'b0;
      if (cand_q == att_q) begin
        pend_d = cand_q;
        cnt_d  = '0;
      end else if (cand_q != pend_q) begin
        pend_d = cand_q;
        cnt_d  = 4'd1;
      end else if (cnt_q + 4'd1 == HOLD) begin
        att_d = cand_q;
        cnt_d = '0;
        chg_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    if (i_Valid) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d   = TMO_MAX;
      stale_d = 1'b1;
      att_d   = '0;
      pend_d  = '0;
      cnt_d   = '0;
      chg_d   = (att_q != 4'd0);
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      cand_q   <= '0;
      att_q    <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      chg_q    <= 1'b0;
      stale_q  <= 1'b1;
    end else begin
      s1_vld_q <= i_Valid;
      s2_vld_q <= s1_vld_q;
      cand_q   <= cand_d;
      att_q    <= att_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      chg_q    <= chg_d;
      stale_q  <= stale_d;
    end
  end

  assign o_Attitude = att_q;
  assign o_Changed  = chg_q;
  assign o_Stale    = stale_q;

endmodule

// File: tb/tb_attitude_classifier.sv
// Self-checking bench: sequential per-sample reference
// model, results delayed two edges, plus timeout model.
module tb_attitude_classifier;

  localparam int HOLD = 4;
  localparam int TMO  = 64;
  localparam int T_ON  = 1820;
  localparam int T_OFF = 1456;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [15:0] roll = '0;
  logic [15:0] pitch = '0;
  logic [3:0]  att;
  logic        chg;
  logic        stale;

  int n_chk = 0;
  int n_fail = 0;
  int chg_seen = 0;

  logic [3:0] m_att, m_pend;
  int         m_cnt;
  int         idle;
  logic [3:0] e_att;
  logic       e_chg, e_stale;
  bit         d1_v, d2_v;
  logic [3:0] d1_att, d2_att;
  logic       d1_chg, d2_chg;

  attitude_classifier #(
    .HOLD_COUNT    (HOLD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Valid   (vld),
    .i_Roll    (roll),
    .i_Pitch   (pitch),
    .o_Attitude(att),
    .o_Changed (chg),
    .o_Stale   (stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h",
               tag, $time, obs, exp);
    end
  endtask

  function automatic logic over_of(input logic [15:0] x,
                                   input logic was);
    int m;
    m = $signed(x);
    if (m < 0) m = -m;
    if (m > 32767) m = 32767;
    return was ? (m >= T_OFF) : (m > T_ON);
  endfunction

  function automatic logic [3:0] classify(input logic [15:0] r,
                                          input logic [15:0] p,
                                          input logic [3:0] cur);
    return {r[15], p[15], over_of(r, cur[1]), over_of(p, cur[0])};
  endfunction

  task automatic model_clear();
    m_att = '0; m_pend = '0; m_cnt = 0; idle = 0;
    e_att = '0; e_chg = 1'b0; e_stale = 1'b1;
    d1_v = 0; d2_v = 0; d1_chg = 0; d2_chg = 0;
    d1_att = '0; d2_att = '0;
  endtask

  task automatic accept(input logic [15:0] r, input logic [15:0] p);
    logic [3:0] c;
    logic       ch;
    c  = classify(r, p, m_att);
    ch = 1'b0;
    if (c == m_att) begin
      m_pend = c; m_cnt = 0;
    end else if (c != m_pend) begin
      m_pend = c; m_cnt = 1;
    end else if (m_cnt + 1 == HOLD) begin
      m_att = c; m_cnt = 0; ch = 1'b1;
    end else begin
      m_cnt++;
    end
    d1_v = 1; d1_att = m_att; d1_chg = ch;
  endtask

  task automatic step(input bit v, input logic [15:0] r,
                      input logic [15:0] p);
    @(negedge clk);
    vld   = v;
    roll  = v ? r : 16'($urandom);
    pitch = v ? p : 16'($urandom);
    @(posedge clk);
    e_chg = 1'b0;
    if (d2_v) begin
      e_att = d2_att; e_chg = d2_chg; e_stale = 1'b0;
    end
    d2_v = d1_v; d2_att = d1_att; d2_chg = d1_chg;
    d1_v = 0; d1_chg = 0;
    if (v) begin
      idle = 0;
      accept(r, p);
    end else begin
      idle++;
      if (idle == TMO) begin
        m_att = '0; m_pend = '0; m_cnt = 0;
        e_chg = (e_att != 4'd0);
        e_att = '0; e_stale = 1'b1;
      end
    end
    #1;
    if (chg) chg_seen++;
    check("att", att, e_att);
    check("chg", chg, e_chg);
    check("stale", stale, e_stale);
  endtask

  task automatic rep(input int n, input logic [15:0] r,
                     input logic [15:0] p);
    for (int i = 0; i < n; i++) step(1, r, p);
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'd0, 16'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vld = 1'b0;
    #1;
    check("rst_att", att, 4'd0);
    check("rst_chg", chg, 1'b0);
    check("rst_stale", stale, 1'b1);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [15:0] pal [8];
    logic [15:0] r, p;
    pal[0] = 16'd0;     pal[1] = 16'd2000;
    pal[2] = -16'd2000; pal[3] = 16'd1500;
    pal[4] = 16'd1820;  pal[5] = 16'd1456;
    pal[6] = 16'h8000;  pal[7] = 16'd1455;
    model_clear();
    do_reset();

    wait_idle(3);
    check("r029_stale0", stale, 1'b1);
    chg_seen = 0;
    step(1, 16'd0, 16'd0);
    wait_idle(3);
    check("r029_stale1", stale, 1'b0);
    check("r029_att", att, 4'b0000);
    check("r029_nochg", chg_seen, 0);

    rep(3, 16'd0, 16'd2000);
    step(1, 16'd0, 16'd0);
    wait_idle(4);
    check("r030_nocommit", att, 4'b0000);
    chg_seen = 0;
    rep(4, 16'd0, 16'd2000);
    wait_idle(1);
    check("r030_lat1", att, 4'b0000);
    wait_idle(1);
    check("r030_lat2", att, 4'b0001);
    wait_idle(2);
    check("r030_pulses", chg_seen, 1);

    rep(8, 16'd0, 16'd1500);
    wait_idle(3);
    check("r031_1500", att, 4'b0001);
    rep(8, 16'd0, 16'd1456);
    wait_idle(3);
    check("r031_1456", att, 4'b0001);
    rep(4, 16'd0, 16'd1455);
    wait_idle(3);
    check("r031_1455", att, 4'b0000);

    rep(4, 16'h8000, -16'd2000);
    wait_idle(3);
    check("r032_1111", att, 4'b1111);
    rep(4, 16'd0, 16'd0);
    wait_idle(3);
    rep(6, 16'd1820, 16'd1820);
    wait_idle(3);
    check("r032_eq_on", att, 4'b0000);

    rep(4, 16'h8000, -16'd2000);
    wait_idle(2);
    chg_seen = 0;
    wait_idle(TMO);
    check("r033_stale", stale, 1'b1);
    check("r033_att", att, 4'b0000);
    check("r033_pulses", chg_seen, 1);
    rep(4, 16'h8000, -16'd2000);
    wait_idle(TMO - 1);
    step(1, 16'h8000, -16'd2000);
    wait_idle(4);
    check("r033_nostale", stale, 1'b0);
    check("r033_hold", att, 4'b1111);

    rep(3, 16'd0, 16'd2000);
    do_reset();
    step(1, 16'd0, 16'd2000);
    wait_idle(4);
    check("r034_one", att, 4'b0000);
    rep(3, 16'd0, 16'd2000);
    wait_idle(3);
    check("r034_four", att, 4'b0001);

    for (int k = 0; k < 400; k++) begin
      r = pal[$urandom_range(0, 7)];
      p = pal[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) r = 16'($urandom);
      if ($urandom_range(0, 3) == 0) p = -p;
      for (int j = $urandom_range(1, 6); j > 0; j--) begin
        step(1, r, p);
        if ($urandom_range(0, 2) == 0)
          wait_idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 40) == 0) wait_idle(TMO + 4);
      if ($urandom_range(0, 80) == 0) do_reset();
    end
    wait_idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
